// File: rtl/spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_param
// Brief    : Parametrised SPI slave. Supports all four CPOL/CPHA modes, MSB or
//            LSB first, and a configurable word width. Host side uses valid/
//            ready handshakes. SCK/CS/MOSI are oversampled on clk_i through a
//            SYNC_STAGES-deep synchroniser. Error flags are sticky.
//            Optional macro SPI_SLAVE_MULTIWORD_EN lets one frame carry
//            several back-to-back words.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_param #(
    parameter int                DATA_W      = 16,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_FILL     = {DATA_W{1'b1}}
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic              conf_cpol,
    input  logic              conf_cpha,
    input  logic              conf_dir,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              err_overrun,
    output logic              err_underrun,
    output logic              err_frame,
    input  logic              err_clear
);

    localparam int                 c_CNT_W       = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL    = c_CNT_W'(DATA_W);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST    = c_CNT_W'(DATA_W - 1);
    localparam int                 c_SETTLE_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_DONE = c_SETTLE_W'(SYNC_STAGES);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOAD   = 2'd1;
    localparam logic [1:0] c_ST_ACTIVE = 2'd2;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [c_SETTLE_W-1:0]  r_settle;
    logic                   r_armed;

    logic [1:0]             r_state;
    logic                   r_edge_inv;
    logic                   r_cpha;
    logic                   r_dir;
    logic                   r_skip;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [DATA_W-1:0]      r_tx_shift;
    logic [DATA_W-1:0]      r_rx_shift;
    logic [DATA_W-1:0]      r_tx_hold;
    logic                   r_tx_full;
`ifdef SPI_SLAVE_MULTIWORD_EN
    logic                   r_reload_pend;
`endif

    logic                   w_sck_new;
    logic                   w_sck_old;
    logic                   w_sck_rise;
    logic                   w_sck_fall;
    logic                   w_cs_fall;
    logic                   w_mosi;
    logic                   w_active;
    logic                   w_cs_end;
    logic                   w_sample;
    logic                   w_shift;
    logic                   w_done_word;
    logic                   w_extra_sample;
    logic                   w_reload;
    logic                   w_tx_take;
    logic                   w_tx_consume;
    logic [DATA_W-1:0]      w_tx_word;
    logic                   w_tx_first;
    logic [DATA_W-1:0]      w_rx_next;
    logic                   w_set_underrun;
    logic                   w_set_overrun;
    logic                   w_set_frame;

    // Pin synchronisers; reset to the idle bus level so no spurious edge appears
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_sck_sync  <= {SYNC_STAGES{conf_cpol}};
            r_cs_sync   <= {SYNC_STAGES{1'b1}};
            r_mosi_sync <= '0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    // After reset, wait for the synchroniser to hold real pin levels and for CS
    // to be seen idle, so a frame already running at reset release is ignored
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_settle <= '0;
            r_armed  <= 1'b0;
        end else if (r_settle != c_SETTLE_DONE) begin
            r_settle <= r_settle + c_SETTLE_W'(1);
        end else if (r_cs_sync[SYNC_STAGES-1]) begin
            r_armed  <= 1'b1;
        end
    end

    assign w_sck_new  = r_sck_sync[SYNC_STAGES-2];
    assign w_sck_old  = r_sck_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_new & ~w_sck_old;
    assign w_sck_fall = ~w_sck_new & w_sck_old;
    assign w_cs_fall  = ~r_cs_sync[SYNC_STAGES-2] & r_cs_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];

    // Frame events; an inverted mode (cpol^cpha) samples on the falling edge
    assign w_active       = (r_state == c_ST_ACTIVE);
    assign w_cs_end       = w_active & r_cs_sync[SYNC_STAGES-1];
    assign w_sample       = w_active & ~w_cs_end & (r_edge_inv ? w_sck_fall : w_sck_rise);
    assign w_shift        = w_active & ~w_cs_end & (r_edge_inv ? w_sck_rise : w_sck_fall);
    assign w_done_word    = w_sample & (r_cnt == c_CNT_LAST);
    assign w_extra_sample = w_sample & (r_cnt == c_CNT_FULL);
    assign w_rx_next      = r_dir ? {w_mosi, r_rx_shift[DATA_W-1:1]}
                                  : {r_rx_shift[DATA_W-2:0], w_mosi};

`ifdef SPI_SLAVE_MULTIWORD_EN
    assign w_reload = w_shift & r_reload_pend;
`else
    assign w_reload = 1'b0;
`endif

    // Word taken from the holding register at frame start or mid-frame reload
    assign w_tx_take      = (r_state == c_ST_LOAD) | w_reload;
    assign w_tx_consume   = w_tx_take & r_tx_full;
    assign w_set_underrun = w_tx_take & ~r_tx_full;
    assign w_tx_word      = r_tx_full ? r_tx_hold : TX_FILL;
    assign w_tx_first     = r_dir ? w_tx_word[0] : w_tx_word[DATA_W-1];

    assign w_set_overrun  = w_done_word & rx_valid & ~rx_ready;
    assign w_set_frame    = (w_cs_end & (r_cnt != '0) & (r_cnt != c_CNT_FULL)) | w_extra_sample;

    assign tx_ready = ~r_tx_full;

    // TX holding register: one-word buffer between host and shift register
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_tx_hold <= '0;
            r_tx_full <= 1'b0;
        end else if (w_tx_consume) begin
            r_tx_full <= 1'b0;
        end else if (tx_valid && !r_tx_full) begin
            r_tx_hold <= tx_data;
            r_tx_full <= 1'b1;
        end
    end

    // Frame state machine: config latch, bit counting, MISO/MOSI shifting
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_edge_inv    <= 1'b0;
            r_cpha        <= 1'b0;
            r_dir         <= 1'b0;
            r_skip        <= 1'b0;
            r_cnt         <= '0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            spi_miso      <= 1'b0;
            spi_miso_oe   <= 1'b0;
            busy          <= 1'b0;
`ifdef SPI_SLAVE_MULTIWORD_EN
            r_reload_pend <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    spi_miso_oe <= 1'b0;
                    busy        <= 1'b0;
                    if (w_cs_fall && r_armed) begin
                        r_edge_inv <= conf_cpol ^ conf_cpha;
                        r_cpha     <= conf_cpha;
                        r_dir      <= conf_dir;
                        r_state    <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    r_tx_shift    <= w_tx_word;
                    spi_miso      <= w_tx_first;
                    r_cnt         <= '0;
                    r_skip        <= r_cpha;
                    spi_miso_oe   <= 1'b1;
                    busy          <= 1'b1;
`ifdef SPI_SLAVE_MULTIWORD_EN
                    r_reload_pend <= 1'b0;
`endif
                    r_state       <= c_ST_ACTIVE;
                end
                c_ST_ACTIVE: begin
                    if (w_cs_end) begin
                        r_state     <= c_ST_IDLE;
                        spi_miso_oe <= 1'b0;
                        busy        <= 1'b0;
                        r_cnt       <= '0;
                    end else begin
`ifdef SPI_SLAVE_MULTIWORD_EN
                        if (w_sample) begin
                            r_rx_shift <= w_rx_next;
                            if (r_cnt == c_CNT_LAST) begin
                                r_cnt         <= '0;
                                r_reload_pend <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + c_CNT_W'(1);
                            end
                        end
                        if (w_shift) begin
                            if (r_reload_pend) begin
                                r_tx_shift    <= w_tx_word;
                                spi_miso      <= w_tx_first;
                                r_reload_pend <= 1'b0;
                                r_skip        <= 1'b0;
                            end else if (r_skip) begin
                                r_skip <= 1'b0;
                            end else if (r_dir) begin
                                r_tx_shift <= r_tx_shift >> 1;
                                spi_miso   <= r_tx_shift[1];
                            end else begin
                                r_tx_shift <= r_tx_shift << 1;
                                spi_miso   <= r_tx_shift[DATA_W-2];
                            end
                        end
`else
                        // Once the word is complete, further SCK edges are ignored
                        if (w_sample && (r_cnt != c_CNT_FULL)) begin
                            r_rx_shift <= w_rx_next;
                            r_cnt      <= r_cnt + c_CNT_W'(1);
                        end
                        if (w_shift && (r_cnt != c_CNT_FULL)) begin
                            if (r_skip) begin
                                r_skip <= 1'b0;
                            end else if (r_dir) begin
                                r_tx_shift <= r_tx_shift >> 1;
                                spi_miso   <= r_tx_shift[1];
                            end else begin
                                r_tx_shift <= r_tx_shift << 1;
                                spi_miso   <= r_tx_shift[DATA_W-2];
                            end
                        end
`endif
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // RX output register; a completion coinciding with an accept is stored
    always_ff @(posedge clk_i) begin
        if (reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (w_done_word && (!rx_valid || rx_ready)) begin
            rx_data  <= w_rx_next;
            rx_valid <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new set beats a simultaneous clear
    always_ff @(posedge clk_i) begin
        if (reset) begin
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
            err_frame    <= 1'b0;
        end else begin
            err_overrun  <= (err_overrun  & ~err_clear) | w_set_overrun;
            err_underrun <= (err_underrun & ~err_clear) | w_set_underrun;
            err_frame    <= (err_frame    & ~err_clear) | w_set_frame;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_param
// Brief    : Self-checking bench for spi_slave_param: directed scenarios plus
//            randomized frames compared against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_param;

    localparam int DW   = 16;
    localparam int SS   = 2;
    localparam int HALF = 6;
    localparam logic [DW-1:0] FILL = {DW{1'b1}};

    logic          clk_i = 1'b0;
    logic          reset;
    logic          spi_sck, spi_cs_n, spi_mosi;
    logic          spi_miso, spi_miso_oe;
    logic          conf_cpol, conf_cpha, conf_dir;
    logic [DW-1:0] tx_data;
    logic          tx_valid, tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid, rx_ready;
    logic          busy, err_overrun, err_underrun, err_frame, err_clear;

    int n_vec = 0;
    int n_bad = 0;

    // Frame-level model of the slave's host-visible state
    logic [DW-1:0] m_rx_data;
    bit            m_rx_valid, m_ovr, m_und, m_frm, m_tx_full;
    logic [DW-1:0] m_tx_word;

    int   cyc = 0;
    int   rise_cyc = 0;
    int   last_sample_cyc = 0;
    logic prev_rxv = 1'b0;
    logic [DW-1:0] got_q[$];

    spi_slave_param #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk_i(clk_i), .reset(reset),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .conf_cpol(conf_cpol), .conf_cpha(conf_cpha), .conf_dir(conf_dir),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .err_overrun(err_overrun), .err_underrun(err_underrun),
        .err_frame(err_frame), .err_clear(err_clear)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (rx_valid && !prev_rxv) rise_cyc <= cyc;
        prev_rxv <= rx_valid;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_miso"}, spi_miso, 0);
        check({tag, "_oe"}, spi_miso_oe, 0);
        check({tag, "_txrdy"}, tx_ready, 1);
        check({tag, "_rxdata"}, rx_data, 0);
        check({tag, "_rxv"}, rx_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_errs"}, {err_overrun, err_underrun, err_frame}, 0);
    endtask

    task automatic model_reset();
        m_rx_data = '0; m_rx_valid = 0; m_ovr = 0; m_und = 0; m_frm = 0;
        m_tx_full = 0; m_tx_word = '0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_rxv"}, rx_valid, m_rx_valid);
        check({tag, "_rxdata"}, rx_data, m_rx_data);
        check({tag, "_ovr"}, err_overrun, m_ovr);
        check({tag, "_und"}, err_underrun, m_und);
        check({tag, "_frm"}, err_frame, m_frm);
        check({tag, "_txrdy"}, tx_ready, !m_tx_full);
        check({tag, "_idle"}, {busy, spi_miso_oe}, 0);
    endtask

    task automatic push_tx(input logic [DW-1:0] w);
        int k;
        k = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && k < 20) begin
            wait_clk(1);
            k++;
        end
        check("push_ready", tx_ready, 1);
        wait_clk(1);
        tx_valid = 1'b0;
        check("push_taken", tx_ready, 0);
        m_tx_full = 1;
        m_tx_word = w;
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        check("accept_drop", rx_valid, 0);
        m_rx_valid = 0;
    endtask

    task automatic clear_err();
        err_clear = 1'b1;
        wait_clk(1);
        err_clear = 1'b0;
        m_ovr = 0; m_und = 0; m_frm = 0;
        check("err_cleared", {err_overrun, err_underrun, err_frame}, 0);
    endtask

    // Master side: bits go out in index order nbits-1..0 (MSB first) or 0..nbits-1
    task automatic spi_xfer(input bit cpol, input bit cpha, input bit dir,
                            input logic [31:0] mosi_w, input int nbits,
                            input bit keep_cs, output logic [31:0] miso_w);
        conf_cpol = cpol; conf_cpha = cpha; conf_dir = dir;
        spi_sck = cpol;
        wait_clk(HALF);
        spi_cs_n = 1'b0;
        wait_clk(HALF);
        miso_w = '0;
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = dir ? i : nbits - 1 - i;
            if (!cpha) begin
                spi_mosi = mosi_w[idx];
                wait_clk(HALF);
                spi_sck = ~cpol;
                miso_w[idx] = spi_miso;
                last_sample_cyc = cyc;
                wait_clk(HALF);
                spi_sck = cpol;
            end else begin
                spi_sck = ~cpol;
                spi_mosi = mosi_w[idx];
                wait_clk(HALF);
                spi_sck = cpol;
                miso_w[idx] = spi_miso;
                last_sample_cyc = cyc;
                wait_clk(HALF);
            end
        end
        if (!keep_cs) begin
            wait_clk(HALF);
            spi_cs_n = 1'b1;
            wait_clk(2 * HALF);
        end
    endtask

    // Apply one complete frame to the model; returns the word the master should read
    task automatic model_frame(input bit cpha, input bit dir, input logic [31:0] mosi_w,
                               input int nbits, output logic [DW-1:0] exp_miso);
        int loads, words;
        logic [31:0] w;
`ifdef SPI_SLAVE_MULTIWORD_EN
        loads = 1 + (cpha ? (nbits - 1) / DW : nbits / DW);
        words = nbits / DW;
        if ((nbits % DW) != 0) m_frm = 1;
`else
        loads = 1;
        words = (nbits >= DW) ? 1 : 0;
        if (nbits != DW) m_frm = 1;
`endif
        exp_miso = m_tx_full ? m_tx_word : FILL;
        for (int l = 0; l < loads; l++) begin
            if (m_tx_full) m_tx_full = 0;
            else m_und = 1;
        end
        for (int k = 0; k < words; k++) begin
            w = dir ? (mosi_w >> (k * DW)) : (mosi_w >> (nbits - (k + 1) * DW));
            if (!m_rx_valid) begin
                m_rx_data  = w[DW-1:0];
                m_rx_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    task automatic full_frame(input string tag, input bit cpol, input bit cpha, input bit dir,
                              input logic [DW-1:0] mosi_w);
        logic [31:0] got;
        logic [DW-1:0] exp_m;
        model_frame(cpha, dir, {16'h0, mosi_w}, DW, exp_m);
        spi_xfer(cpol, cpha, dir, {16'h0, mosi_w}, DW, 0, got);
        check({tag, "_miso"}, got[DW-1:0], exp_m);
        check_state(tag);
    endtask

    initial begin
        logic [31:0] got;
        logic [DW-1:0] exp_m;
        int base;
        reset = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        conf_cpol = 1'b0; conf_cpha = 1'b0; conf_dir = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; err_clear = 1'b0;
        model_reset();
        wait_clk(5);
        check_reset_vals("rst");
        reset = 1'b0;
        wait_clk(6);

        // Mode 0, MSB first, with receive latency bound
        push_tx(16'hA55A);
        full_frame("t1", 0, 0, 0, 16'h1234);
        check("t1_latency", (rise_cyc >= last_sample_cyc) && (rise_cyc - last_sample_cyc <= SS + 3), 1);
        accept();

        // Mode 3, LSB first
        push_tx(16'h00FF);
        full_frame("t2", 1, 1, 1, 16'h8001);
        accept();

        // Underrun: no word queued
        full_frame("t3", 0, 0, 0, 16'h0F0F);
        clear_err();
        accept();

        // Overrun: second word dropped while rx_ready is low
        push_tx(16'h3C3C);
        full_frame("t4a", 0, 0, 0, 16'h1111);
        push_tx(16'hC3C3);
        full_frame("t4b", 0, 0, 0, 16'h2222);
        accept();
        clear_err();

        // Truncated frame then a good one
        push_tx(16'h1357);
        model_frame(0, 0, 32'h55, 7, exp_m);
        spi_xfer(0, 0, 0, 32'h55, 7, 0, got);
        check_state("t5a");
        clear_err();
        push_tx(16'h2468);
        full_frame("t5b", 0, 1, 0, 16'hBEEF);
        accept();

`ifndef SPI_SLAVE_MULTIWORD_EN
        // One sample edge too many: word still delivered, frame error raised
        push_tx(16'h7777);
        model_frame(0, 0, 32'h1ABCD, 17, exp_m);
        spi_xfer(0, 0, 0, 32'h1ABCD, 17, 0, got);
        check_state("t_over");
        clear_err();
        accept();
`endif

        // Reset in the middle of a mode 1 frame
        push_tx(16'h9999);
        spi_xfer(0, 1, 0, 32'hF0, 8, 1, got);
        check("t6_busy", {busy, spi_miso_oe}, 2'b11);
        reset = 1'b1;
        wait_clk(1);
        check_reset_vals("t6");
        reset = 1'b0;
        model_reset();
        spi_cs_n = 1'b1;
        wait_clk(2 * HALF);
        push_tx(16'h6C6C);
        full_frame("t6b", 0, 1, 0, 16'h5A5A);
        accept();

`ifdef SPI_SLAVE_MULTIWORD_EN
        // Two words inside one frame, host accepting as they arrive
        base = got_q.size();
        push_tx(16'h4242);
        rx_ready = 1'b1;
        spi_xfer(0, 1, 0, 32'hCAFEF00D, 32, 0, got);
        rx_ready = 1'b0;
        check("mw_count", got_q.size() - base, 2);
        if (got_q.size() >= base + 2) begin
            check("mw_w0", got_q[base], 16'hCAFE);
            check("mw_w1", got_q[base + 1], 16'hF00D);
        end
        m_tx_full = 0; m_und = 1; m_rx_data = 16'hF00D; m_rx_valid = 0;
        check_state("mw");
        clear_err();
`endif

        // Randomized frames across modes, bit orders and TX availability
        for (int r = 0; r < 10; r++) begin
            bit cpol, cpha, dir, give;
            logic [DW-1:0] mw;
            cpol = 1'($urandom_range(0, 1));
            cpha = 1'($urandom_range(0, 1));
            dir  = 1'($urandom_range(0, 1));
            give = ($urandom_range(0, 3) != 0);
            mw   = DW'($urandom);
            if (give) push_tx(DW'($urandom));
            full_frame("rnd", cpol, cpha, dir, mw);
            accept();
            if (m_ovr || m_und || m_frm) clear_err();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
